forward_ns_rr_router: RTL and testbench

Parametrised successor to the north/south forwarding stage of the mesh router. It accepts packets from `NUM_IN` upstream FIFOs and arbitrates between them round-robin, so no input has fixed priority. Each winning packet is routed on its signed DY field: DY == 0 goes to the local buffer with DY stripped; any other DY is stepped toward zero and goes to the routing buffer. The block sits between the west/east/routing input FIFOs and the next hop (or the local neuron core), and exposes saturating traffic counters for the host.

---
 rtl/router_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/sync_buffer.sv | 53 +++++
 rtl/forward_ns_rr_router.sv | 143 ++++++++++++++
 tb/tb_forward_ns_rr_router.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared constants and helpers for the north/south forwarding routers.
package router_pkg;

    // Working width of the generic helper functions below.
    localparam int unsigned FN_W = 64;

    // Width of the signed DY field.
    function automatic int unsigned dy_width(input int unsigned msb, input int unsigned lsb);
        return msb - lsb + 1;
    endfunction

    // Step applied to a non-zero DY: north moves toward zero by -1, south by +1.
    function automatic int dy_add(input int unsigned north);
        return (north != 0) ? -1 : 1;
    endfunction

    // Remove bits [msb:lsb] and close the gap.
    function automatic logic [FN_W-1:0] strip_dy(input logic [FN_W-1:0] pkt,
                                                 input int unsigned msb,
                                                 input int unsigned lsb);
        logic [FN_W-1:0] lo_mask;
        lo_mask = (FN_W'(1) << lsb) - FN_W'(1);
        return (pkt & lo_mask) | ((pkt >> (msb + 1)) << lsb);
    endfunction

    // Increment that sticks at the all-ones value of a w-bit counter.
    function automatic logic [FN_W-1:0] sat_inc(input logic [FN_W-1:0] cnt, input int unsigned w);
        logic [FN_W-1:0] max_val;
        max_val = (w >= FN_W) ? '1 : ((FN_W'(1) << w) - FN_W'(1));
        return (cnt == max_val) ? cnt : cnt + FN_W'(1);
    endfunction

    // Modulo-n successor of an index.
    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, with wrap.
module rr_arbiter
    import router_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]          req,
    input  logic                  en,
    input  logic [$clog2(N)-1:0]  ptr,
    output logic [N-1:0]          gnt,
    output logic [$clog2(N)-1:0]  ptr_next
);
    localparam int unsigned PW = $clog2(N);

    // Search upward from ptr; the pointer moves past the winner.
    always_comb begin
        int unsigned c;
        logic        found;
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        c        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            c = (32'(ptr) + k) % N;
            if (en && !found && req[c]) begin
                gnt[c]   = 1'b1;
                ptr_next = PW'(wrap_inc(c, N));
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_buffer.sv
// Synchronous first-word-fall-through buffer with occupancy output.
module sync_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wen,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     ren,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Pop only when data exists; push only when room exists after any pop.
    always_comb begin
        do_pop  = ren && (count != '0);
        do_push = wen && ((count != OW'(DEPTH)) || do_pop);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + OW'(do_push) - OW'(do_pop);
        end
    end

    // Storage array; contents are discarded logically by the count reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign empty     = (count == '0);
    assign rdata     = empty ? '0 : mem[rd_ptr];
    assign occupancy = count;

endmodule

// File: rtl/forward_ns_rr_router.sv
// North/south forwarding stage: round-robin input select, DY decode, two output buffers.
module forward_ns_rr_router
    import router_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH = 21,
    parameter int unsigned DY_MSB       = 20,
    parameter int unsigned DY_LSB       = 12,
    parameter int unsigned BUFFER_DEPTH = 4,
    parameter int unsigned NUM_IN       = 3,
    parameter int unsigned NORTH        = 1,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_IN*PACKET_WIDTH-1:0]                  din,
    input  logic [NUM_IN-1:0]                               empty,
    output logic [NUM_IN-1:0]                               ren_out,
    input  logic                                            ren_in_routing,
    input  logic                                            ren_in_local,
    output logic [PACKET_WIDTH-1:0]                         dout_routing,
    output logic [PACKET_WIDTH-dy_width(DY_MSB,DY_LSB)-1:0] dout_local,
    output logic                                            routing_buffer_empty,
    output logic                                            local_buffer_empty,
    output logic [CNT_WIDTH-1:0]                            fwd_count,
    output logic [CNT_WIDTH-1:0]                            local_count,
    input  logic                                            clr_counts
);
    localparam int unsigned DYW = dy_width(DY_MSB, DY_LSB);
    localparam int unsigned LW  = PACKET_WIDTH - DYW;
    localparam int unsigned PW  = $clog2(NUM_IN);
    localparam int unsigned OW  = $clog2(BUFFER_DEPTH) + 1;
    localparam int unsigned SW  = OW + 1;
    localparam logic [DYW-1:0] ADD = DYW'(dy_add(NORTH));

    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           ptr_next;
    logic [NUM_IN-1:0]       gnt;
    logic                    stall;
    logic                    grant_en;
    logic [PACKET_WIDTH-1:0] sel_data;
    logic                    stage_valid;
    logic [PACKET_WIDTH-1:0] stage_data;
    logic [DYW-1:0]          dy;
    logic                    pend_r;
    logic                    pend_l;
    logic [PACKET_WIDTH-1:0] routed_data;
    logic [LW-1:0]           local_data;
    logic [OW-1:0]           occ_r;
    logic [OW-1:0]           occ_l;

    // Hold off grants while either buffer could overflow once the staged packet lands.
    always_comb begin
        stall = (SW'(occ_r) + SW'(pend_r) >= SW'(BUFFER_DEPTH)) ||
                (SW'(occ_l) + SW'(pend_l) >= SW'(BUFFER_DEPTH));
        grant_en = !stall && !reset;
    end

    rr_arbiter #(
        .N(NUM_IN)
    ) u_arb (
        .req      (~empty),
        .en       (grant_en),
        .ptr      (rr_ptr),
        .gnt      (gnt),
        .ptr_next (ptr_next)
    );

    assign ren_out = gnt;

    // One-hot select of the winning head word.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (gnt[i]) sel_data = sel_data | din[i*PACKET_WIDTH +: PACKET_WIDTH];
        end
    end

    // Stage register and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
            rr_ptr      <= '0;
        end else begin
            stage_valid <= |gnt;
            if (|gnt) stage_data <= sel_data;
            rr_ptr <= ptr_next;
        end
    end

    // Decode the staged packet: DY == 0 goes local stripped, otherwise step DY and forward.
    always_comb begin
        dy          = stage_data[DY_MSB:DY_LSB];
        pend_l      = stage_valid && (dy == '0);
        pend_r      = stage_valid && (dy != '0);
        routed_data = stage_data;
        routed_data[DY_MSB:DY_LSB] = dy + ADD;
        local_data  = LW'(strip_dy(FN_W'(stage_data), DY_MSB, DY_LSB));
    end

    // Saturating traffic counters; clear wins over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_count   <= '0;
            local_count <= '0;
        end else if (clr_counts) begin
            fwd_count   <= '0;
            local_count <= '0;
        end else begin
            if (pend_r) fwd_count   <= CNT_WIDTH'(sat_inc(FN_W'(fwd_count), CNT_WIDTH));
            if (pend_l) local_count <= CNT_WIDTH'(sat_inc(FN_W'(local_count), CNT_WIDTH));
        end
    end

    sync_buffer #(
        .WIDTH (PACKET_WIDTH),
        .DEPTH (BUFFER_DEPTH)
    ) u_routing_buf (
        .clk       (clk),
        .reset     (reset),
        .wen       (pend_r),
        .wdata     (routed_data),
        .ren       (ren_in_routing),
        .rdata     (dout_routing),
        .empty     (routing_buffer_empty),
        .occupancy (occ_r)
    );

    sync_buffer #(
        .WIDTH (LW),
        .DEPTH (BUFFER_DEPTH)
    ) u_local_buf (
        .clk       (clk),
        .reset     (reset),
        .wen       (pend_l),
        .wdata     (local_data),
        .ren       (ren_in_local),
        .rdata     (dout_local),
        .empty     (local_buffer_empty),
        .occupancy (occ_l)
    );

endmodule

// File: tb/tb_forward_ns_rr_router.sv
// Directed bench for forward_ns_rr_router: a north instance and a south instance.
module tb_forward_ns_rr_router;

    logic        clk = 1'b0;
    logic        reset;

    logic [62:0] din;
    logic [2:0]  empty;
    logic [2:0]  ren_out;
    logic        ren_in_routing;
    logic        ren_in_local;
    logic [20:0] dout_routing;
    logic [11:0] dout_local;
    logic        routing_buffer_empty;
    logic        local_buffer_empty;
    logic [15:0] fwd_count;
    logic [15:0] local_count;
    logic        clr_counts;

    logic [62:0] s_din;
    logic [2:0]  s_empty;
    logic [2:0]  s_ren_out;
    logic        s_ren_in_routing;
    logic        s_ren_in_local;
    logic [20:0] s_dout_routing;
    logic [11:0] s_dout_local;
    logic        s_rbe;
    logic        s_lbe;
    logic [15:0] s_fwd_count;
    logic [15:0] s_local_count;
    logic        s_clr_counts;

    int n_cmp = 0;
    int n_err = 0;
    int remaining;

    always #5 clk = ~clk;

    forward_ns_rr_router #(.NORTH(1)) dut (
        .clk                  (clk),
        .reset                (reset),
        .din                  (din),
        .empty                (empty),
        .ren_out              (ren_out),
        .ren_in_routing       (ren_in_routing),
        .ren_in_local         (ren_in_local),
        .dout_routing         (dout_routing),
        .dout_local           (dout_local),
        .routing_buffer_empty (routing_buffer_empty),
        .local_buffer_empty   (local_buffer_empty),
        .fwd_count            (fwd_count),
        .local_count          (local_count),
        .clr_counts           (clr_counts)
    );

    forward_ns_rr_router #(.NORTH(0)) dut_s (
        .clk                  (clk),
        .reset                (reset),
        .din                  (s_din),
        .empty                (s_empty),
        .ren_out              (s_ren_out),
        .ren_in_routing       (s_ren_in_routing),
        .ren_in_local         (s_ren_in_local),
        .dout_routing         (s_dout_routing),
        .dout_local           (s_dout_local),
        .routing_buffer_empty (s_rbe),
        .local_buffer_empty   (s_lbe),
        .fwd_count            (s_fwd_count),
        .local_count          (s_local_count),
        .clr_counts           (s_clr_counts)
    );

    function automatic logic [20:0] pkt(input logic [8:0] dy, input logic [11:0] pl);
        return {dy, pl};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        empty            = '1;
        s_empty          = '1;
        ren_in_routing   = 1'b0;
        ren_in_local     = 1'b0;
        s_ren_in_routing = 1'b0;
        s_ren_in_local   = 1'b0;
        clr_counts       = 1'b0;
        s_clr_counts     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] e;
        reset = 1'b1;
        din = '0; s_din = '0;
        empty = '1; s_empty = '1;
        ren_in_routing = 1'b0; ren_in_local = 1'b0;
        s_ren_in_routing = 1'b0; s_ren_in_local = 1'b0;
        clr_counts = 1'b0; s_clr_counts = 1'b0;

        // Reset values
        @(negedge clk); #1;
        check("rst_ren", ren_out, 3'b000);
        check("rst_rbe", routing_buffer_empty, 1'b1);
        check("rst_lbe", local_buffer_empty, 1'b1);
        check("rst_dout_r", dout_routing, 21'h0);
        check("rst_dout_l", dout_local, 12'h0);
        check("rst_fwd", fwd_count, 16'h0);
        check("rst_loc", local_count, 16'h0);

        // Round robin, all channels busy, DY = 2 -> 1
        do_reset();
        for (int i = 0; i < 3; i++) din[i*21 +: 21] = pkt(9'd2, 12'(i + 1));
        empty = 3'b000;
        ren_in_routing = 1'b1;
        ren_in_local = 1'b1;
        for (int t = 0; t < 9; t++) begin
            #1;
            e = 3'(1 << (t % 3));
            check("rr_gnt", ren_out, e);
            if (t >= 2) check("rr_dout", dout_routing, pkt(9'd1, 12'((t - 2) % 3 + 1)));
            @(negedge clk);
        end
        empty = '1;
        repeat (3) @(negedge clk);
        #1;
        check("rr_fwd", fwd_count, 16'd9);
        check("rr_loc", local_count, 16'd0);
        check("rr_rbe", routing_buffer_empty, 1'b1);

        // Local strip, DY = 0
        do_reset();
        din[20:0] = 21'h000A5;
        empty = 3'b110;
        #1;
        check("loc_gnt", ren_out, 3'b001);
        check("loc_lbe0", local_buffer_empty, 1'b1);
        @(negedge clk);
        empty = '1;
        #1;
        check("loc_lbe1", local_buffer_empty, 1'b1);
        @(negedge clk); #1;
        check("loc_lbe2", local_buffer_empty, 1'b0);
        check("loc_dout", dout_local, 12'h0A5);
        check("loc_cnt", local_count, 16'd1);
        check("loc_fwd", fwd_count, 16'd0);
        check("loc_rbe", routing_buffer_empty, 1'b1);
        ren_in_local = 1'b1;
        @(negedge clk);
        ren_in_local = 1'b0;
        #1;
        check("loc_pop", local_buffer_empty, 1'b1);

        // Backpressure: routing buffer not popped, six packets offered
        do_reset();
        din[21 +: 21] = pkt(9'd3, 12'h3C3);
        remaining = 6;
        for (int t = 0; t < 10; t++) begin
            empty = (remaining > 0) ? 3'b101 : 3'b111;
            #1;
            check("bp_gnt", ren_out, (t < 4) ? 3'b010 : 3'b000);
            if (t < 4) remaining--;
            @(negedge clk);
        end
        #1;
        check("bp_fwd", fwd_count, 16'd4);
        check("bp_rbe", routing_buffer_empty, 1'b0);
        check("bp_dout", dout_routing, pkt(9'd2, 12'h3C3));
        ren_in_routing = 1'b1;
        empty = 3'b101;
        #1;
        check("bp_popcyc", ren_out, 3'b000);
        @(negedge clk);
        ren_in_routing = 1'b0;
        #1;
        check("bp_regrant", ren_out, 3'b010);
        remaining--;
        @(negedge clk); #1;
        check("bp_hold", ren_out, 3'b000);
        @(negedge clk);
        empty = '1;
        repeat (2) @(negedge clk);
        #1;
        check("bp_fwd5", fwd_count, 16'd5);

        // South wrap: DY -1 -> 0, DY 0x0FF -> 0x100
        do_reset();
        s_din[42 +: 21] = pkt(9'h1FF, 12'h123);
        s_empty = 3'b011;
        #1;
        check("wr_gnt0", s_ren_out, 3'b100);
        @(negedge clk);
        s_din[42 +: 21] = pkt(9'h0FF, 12'h456);
        #1;
        check("wr_gnt1", s_ren_out, 3'b100);
        @(negedge clk);
        s_empty = '1;
        #1;
        check("wr_rbe", s_rbe, 1'b0);
        check("wr_dout0", s_dout_routing, pkt(9'h000, 12'h123));
        s_ren_in_routing = 1'b1;
        @(negedge clk); #1;
        check("wr_dout1", s_dout_routing, pkt(9'h100, 12'h456));
        check("wr_fwd", s_fwd_count, 16'd2);
        check("wr_loc", s_local_count, 16'd0);
        @(negedge clk);
        s_ren_in_routing = 1'b0;
        #1;
        check("wr_drain", s_rbe, 1'b1);

        // Counter saturation after 65540 routed packets, then clear with a write
        do_reset();
        din[20:0] = pkt(9'd5, 12'h055);
        empty = 3'b110;
        ren_in_routing = 1'b1;
        repeat (65540) @(negedge clk);
        empty = '1;
        repeat (3) @(negedge clk);
        #1;
        check("sat_fwd", fwd_count, 16'hFFFF);
        empty = 3'b110;
        repeat (3) @(negedge clk);
        clr_counts = 1'b1;
        #1;
        check("sat_pre", fwd_count, 16'hFFFF);
        @(negedge clk);
        clr_counts = 1'b0;
        #1;
        check("clr_prio", fwd_count, 16'd0);
        @(negedge clk); #1;
        check("clr_resume", fwd_count, 16'd1);
        empty = '1;
        repeat (3) @(negedge clk);

        // Reset mid-operation with both buffers partly full and stage valid
        do_reset();
        din[20:0]  = pkt(9'd4, 12'h444);
        din[21 +: 21] = pkt(9'd0, 12'h111);
        empty = 3'b100;
        repeat (3) @(negedge clk);
        #1;
        check("mr_pre_rbe", routing_buffer_empty, 1'b0);
        check("mr_pre_lbe", local_buffer_empty, 1'b0);
        reset = 1'b1;
        #1;
        check("mr_rbe", routing_buffer_empty, 1'b1);
        check("mr_lbe", local_buffer_empty, 1'b1);
        check("mr_ren", ren_out, 3'b000);
        check("mr_fwd", fwd_count, 16'd0);
        empty = '1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mr_post_rbe", routing_buffer_empty, 1'b1);
        check("mr_post_lbe", local_buffer_empty, 1'b1);
        check("mr_post_fwd", fwd_count, 16'd0);
        check("mr_post_loc", local_count, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
